scope_capture: RTL and testbench
================================

SCOPE_CAPTURE -- requirements
Module: scope_capture

Interface
REQ-001 Parameter DEPTH, default 1024, samples per captured trace (one per screen column); a power of two.
REQ-002 Parameter DECIMATE, default 1, accepted-sample divider (1 = keep every valid sample); range 1..255.
REQ-003 clk  input  1  system clock; every register updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 sample_in  input  9  signed two's-complement sample.
REQ-006 sample_valid  input  1  sample_in is valid this cycle.
REQ-007 trigger_en  input  1  1 = wait for a rising-edge trigger; 0 = free-run.
REQ-008 trigger_level  input  9  signed trigger threshold.
REQ-009 frame_start  input  1  one-cycle pulse at the top of each video frame.
REQ-010 freeze  input  1  1 = inhibit bank swaps, so the display trace is held.
REQ-011 overflow_clr  input  1  clears overflow.
REQ-012 hcount  input  11  current display column.
REQ-013 signal_out  output  9  signed trace sample for the column presented one cycle earlier.
REQ-014 signal_valid  output  1  signal_out is meaningful.
REQ-015 capture_state  output  2  00 = ARM, 01 = FILL, 10 = FULL.
REQ-016 overflow  output  1  sticky flag: an accepted sample was dropped.

Function
REQ-017 Storage shall be two banks of DEPTH x 9 bits: the back bank is write-only and the display bank is read-only.
REQ-018 A decimation counter shall count sample_valid pulses; a sample is accepted when the counter equals DECIMATE-1, and the counter then returns to 0.
REQ-019 The decimation counter shall reset to 0 on every ARM entry.
REQ-020 ARM with trigger_en=0: the first accepted sample shall be written at back-bank index 0, and the state shall go to FILL.
REQ-021 ARM with trigger_en=1: an accepted sample shall trigger when prev < trigger_level and sample >= trigger_level, using signed compares, where prev is the last accepted sample.
REQ-022 On a trigger, the triggering sample shall be written at index 0, and the state shall go to FILL.
REQ-023 prev shall be 0 after reset and shall update on every accepted sample in every state.
REQ-024 FILL: each accepted sample shall be written at wr_ptr, and wr_ptr shall then increment.
REQ-025 When the sample at index DEPTH-1 is written, the state shall go to FULL on the next cycle.
REQ-026 FULL: accepted samples shall not be written, and overflow shall set to 1 on the next cycle.
REQ-027 FULL with frame_start=1 and freeze=0: the bank select shall toggle, wr_ptr shall clear, and the state shall be ARM on the next cycle.
REQ-028 FULL with frame_start=1 and freeze=0: shown shall set to 1.
REQ-029 frame_start in ARM or FILL shall be ignored, so no partial trace is ever displayed.
REQ-030 freeze=1 shall hold the state in FULL indefinitely; the display bank shall be unchanged.
REQ-031 overflow_clr shall take priority over a simultaneous drop, so overflow is 0 on the next cycle.
REQ-032 Read path: signal_out and signal_valid shall be registered, with exactly 1 cycle of latency from hcount.
REQ-033 When hcount < DEPTH and shown=1: signal_out shall be display[hcount] and signal_valid shall be 1.
REQ-034 Otherwise: signal_out shall be 0 and signal_valid shall be 0.
REQ-035 A swap shall take effect on reads beginning the cycle after the toggle; no read shall mix banks within one cycle.
REQ-036 A write to the back bank and a read of the display bank in the same cycle shall not interact.

Reset
REQ-037 When rst_n=0 at a clk edge, the following shall load on that edge: state ARM, wr_ptr 0, decimation counter 0, prev 0, bank select 0, shown 0, overflow 0, signal_out 0, signal_valid 0.
REQ-038 Reset shall not require clearing memory contents.
REQ-039 Reset mid-FILL shall abandon the partial trace, and the display shall stay invalid until the next completed swap.
REQ-040 rst_n shall take priority over all other inputs.

Verification
REQ-041 Free-run (trigger_en=0, DECIMATE=1, DEPTH=1024): feed ramp 0..1023 mod 256 as signed values, then pulse frame_start; a sweep of hcount 0..1023 returns the same values 1 cycle later, with signal_valid=1.
REQ-042 Trigger: trigger_level=10, feed -5, 5, 9, 10, 20, ...; index 0 holds 10 and index 1 holds 20; a flat sequence of 10, 10, ... never triggers.
REQ-043 Overflow: after FULL, send 3 samples with no frame_start; overflow=1. Assert overflow_clr together with one more sample; overflow=0 next cycle.
REQ-044 Freeze: freeze=1 with frame_start pulses while FULL; capture_state stays 10 and signal_out is unchanged. Release freeze and pulse frame_start; the swap occurs and the state goes to ARM.
REQ-045 Decimation: DECIMATE=4 with 4096 consecutive valid samples of value n; stored index k equals 4k+3; hcount >= 1024 gives signal_out=0 and signal_valid=0.
REQ-046 Reset: rst_n=0 at wr_ptr=500; next cycle capture_state=00 and signal_valid=0; the next completed trace starts at index 0.

Source files
------------

// File: rtl/scope_capture.sv
// Dual-bank oscilloscope trace capture: decimates and optionally triggers on incoming
// samples, then shows one complete trace per frame for column-by-column readout.
module scope_capture #(
    parameter int DEPTH    = 1024,
    parameter int DECIMATE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic signed [8:0] sample_in,
    input  logic              sample_valid,
    input  logic              trigger_en,
    input  logic signed [8:0] trigger_level,
    input  logic              frame_start,
    input  logic              freeze,
    input  logic              overflow_clr,
    input  logic [10:0]       hcount,
    output logic signed [8:0] signal_out,
    output logic              signal_valid,
    output logic [1:0]        capture_state,
    output logic              overflow
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_ARM  = 2'b00;
    localparam logic [1:0] ST_FILL = 2'b01;
    localparam logic [1:0] ST_FULL = 2'b10;

    logic [1:0]        state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [7:0]        dec_cnt_q, dec_cnt_d;
    logic signed [8:0] prev_q, prev_d;
    logic              bank_q, bank_d;
    logic              shown_q, shown_d;
    logic              overflow_q, overflow_d;

    logic              accept;
    logic              trig_hit;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              rd_hit;
    logic [AW-1:0]     rd_addr;

    // Both banks live in one array: bank_q selects the display half, ~bank_q the back half.
    logic [8:0]        mem [0:2*DEPTH-1];

    // sample_valid has no back-pressure: a sample offered while FULL is counted and dropped.
    assign accept   = sample_valid && (dec_cnt_q == 8'(DECIMATE - 1));
    assign trig_hit = (prev_q < trigger_level) && (sample_in >= trigger_level);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        dec_cnt_d  = dec_cnt_q;
        prev_d     = prev_q;
        bank_d     = bank_q;
        shown_d    = shown_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr_q;

        if (sample_valid) begin
            dec_cnt_d = accept ? 8'd0 : dec_cnt_q + 8'd1;
        end
        if (accept) begin
            prev_d = sample_in;
        end

        case (state_q)
            ST_ARM: begin
                if (accept && (!trigger_en || trig_hit)) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    wr_ptr_d = AW'(1);
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    if (wr_ptr_q == AW'(DEPTH - 1)) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (accept) begin
                    overflow_d = 1'b1;
                end
                // Swap only from FULL so a partial trace is never put on screen.
                if (frame_start && !freeze) begin
                    bank_d    = ~bank_q;
                    wr_ptr_d  = '0;
                    shown_d   = 1'b1;
                    dec_cnt_d = 8'd0;
                    state_d   = ST_ARM;
                end
            end
            default: state_d = ST_ARM;
        endcase

        if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ARM;
            wr_ptr_q   <= '0;
            dec_cnt_q  <= 8'd0;
            prev_q     <= '0;
            bank_q     <= 1'b0;
            shown_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            dec_cnt_q  <= dec_cnt_d;
            prev_q     <= prev_d;
            bank_q     <= bank_d;
            shown_q    <= shown_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{~bank_q, wr_addr}] <= sample_in;
        end
    end

    assign rd_hit  = shown_q && ({21'd0, hcount} < 32'(DEPTH));
    assign rd_addr = AW'(hcount);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            signal_out   <= '0;
            signal_valid <= 1'b0;
        end else begin
            signal_valid <= rd_hit;
            signal_out   <= rd_hit ? mem[{bank_q, rd_addr}] : '0;
        end
    end

    assign capture_state = state_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_scope_capture.sv
// Bench for scope_capture: instances with DECIMATE 1 and 4 share stimulus and are
// compared every cycle against a trace-level model, plus hand-computed spot checks.
module tb_scope_capture;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n;
  logic signed [8:0] sample_in;
  logic signed [8:0] trigger_level;
  logic sample_valid, trigger_en, frame_start, freeze, overflow_clr;
  logic [10:0] hcount;

  logic signed [8:0] so1, so4;
  logic sv1, sv4, ov1, ov4;
  logic [1:0] cs1, cs4;

  int n_tests = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  scope_capture #(.DEPTH(DEPTH), .DECIMATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .trigger_en(trigger_en), .trigger_level(trigger_level), .frame_start(frame_start),
    .freeze(freeze), .overflow_clr(overflow_clr), .hcount(hcount),
    .signal_out(so1), .signal_valid(sv1), .capture_state(cs1), .overflow(ov1)
  );

  scope_capture #(.DEPTH(DEPTH), .DECIMATE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .trigger_en(trigger_en), .trigger_level(trigger_level), .frame_start(frame_start),
    .freeze(freeze), .overflow_clr(overflow_clr), .hcount(hcount),
    .signal_out(so4), .signal_valid(sv4), .capture_state(cs4), .overflow(ov4)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 waiting for first kept sample, 1 collecting, 2 complete trace held
  int m_mode[2];
  int m_nval[2];
  int m_tlen[2];
  logic signed [8:0] m_prev[2];
  bit m_shown[2];
  bit m_ovf[2];
  logic [8:0] m_trace[2][DEPTH];
  logic [8:0] m_disp[2][DEPTH];
  logic [25:0] exp_q[$];

  task automatic model_step(input int m, output logic [12:0] e);
    int d;
    bit acc;
    bit rv;
    logic [8:0] rd;
    d = (m == 0) ? 1 : 4;
    rv = m_shown[m] && (int'(hcount) < DEPTH);
    rd = 9'd0;
    if (rv) rd = m_disp[m][hcount[9:0]];
    if (!rst_n) begin
      m_mode[m] = 0;
      m_nval[m] = 0;
      m_tlen[m] = 0;
      m_prev[m] = 9'sd0;
      m_shown[m] = 1'b0;
      m_ovf[m] = 1'b0;
      e = '0;
      return;
    end
    acc = 1'b0;
    if (sample_valid) begin
      m_nval[m]++;
      acc = (m_nval[m] % d) == 0;
    end
    if (overflow_clr) m_ovf[m] = 1'b0;
    else if (m_mode[m] == 2 && acc) m_ovf[m] = 1'b1;
    case (m_mode[m])
      0: begin
        if (acc && (!trigger_en || (m_prev[m] < trigger_level && sample_in >= trigger_level))) begin
          m_trace[m][0] = sample_in;
          m_tlen[m] = 1;
          m_mode[m] = 1;
        end
      end
      1: begin
        if (acc) begin
          m_trace[m][m_tlen[m]] = sample_in;
          m_tlen[m]++;
          if (m_tlen[m] == DEPTH) m_mode[m] = 2;
        end
      end
      default: begin
        if (frame_start && !freeze) begin
          for (int i = 0; i < DEPTH; i++) m_disp[m][i] = m_trace[m][i];
          m_shown[m] = 1'b1;
          m_tlen[m] = 0;
          m_nval[m] = 0;
          m_mode[m] = 0;
        end
      end
    endcase
    if (acc) m_prev[m] = sample_in;
    e = {m_ovf[m], 2'(m_mode[m]), rv, rd};
  endtask

  always @(posedge clk) begin
    logic [12:0] e0, e1;
    model_step(0, e0);
    model_step(1, e1);
    exp_q.push_back({e0, e1});
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] s9(input int v);
    logic [8:0] t;
    t = 9'(v);
    return {7'd0, t};
  endfunction

  always @(negedge clk) begin
    logic [25:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("d1_overflow", {15'd0, ov1}, {15'd0, e[25]});
      check("d1_state", {14'd0, cs1}, {14'd0, e[24:23]});
      check("d1_valid", {15'd0, sv1}, {15'd0, e[22]});
      check("d1_out", {7'd0, so1}, {7'd0, e[21:13]});
      check("d4_overflow", {15'd0, ov4}, {15'd0, e[12]});
      check("d4_state", {14'd0, cs4}, {14'd0, e[11:10]});
      check("d4_valid", {15'd0, sv4}, {15'd0, e[9]});
      check("d4_out", {7'd0, so4}, {7'd0, e[8:0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [8:0] v);
    sample_in = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  // Random idle gaps, stray frame pulses and read columns while a trace is filling.
  task automatic feed(input logic signed [8:0] v);
    hcount = 11'($urandom_range(0, 1100));
    if ($urandom_range(0, 3) == 0) begin
      frame_start = ($urandom_range(0, 7) == 0);
      tick();
      frame_start = 1'b0;
    end
    send(v);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic signed [8:0] rnd9();
    return 9'($urandom_range(0, 511));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic signed [8:0] first;
    rst_n = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    trigger_en = 1'b0;
    trigger_level = 9'sd10;
    frame_start = 1'b0;
    freeze = 1'b0;
    overflow_clr = 1'b0;
    hcount = '0;

    // Reset values
    do_reset();
    check("rst_state", {14'd0, cs1}, 16'd0);
    check("rst_valid", {15'd0, sv1}, 16'd0);
    check("rst_overflow", {15'd0, ov1}, 16'd0);
    check("rst_out", {7'd0, so1}, 16'd0);

    // Free-running ramp, DECIMATE=1 instance
    for (int i = 0; i < DEPTH; i++) send(9'(i % 256));
    check("ramp_full", {14'd0, cs1}, 16'd2);
    check("ramp_d4_fill", {14'd0, cs4}, 16'd1);
    pulse_frame();
    check("ramp_swap_arm", {14'd0, cs1}, 16'd0);
    for (int h = 0; h < 1040; h++) begin
      hcount = 11'(h);
      tick();
      if (h == 0) check("ramp_h0", {7'd0, so1}, s9(0));
      if (h == 5) check("ramp_h5", {7'd0, so1}, s9(5));
      if (h == 200) check("ramp_h200", {7'd0, so1}, s9(200));
      if (h == 1023) begin
        check("ramp_h1023", {7'd0, so1}, s9(255));
        check("ramp_h1023_valid", {15'd0, sv1}, 16'd1);
      end
      if (h == 1024) check("ramp_h1024_valid", {15'd0, sv1}, 16'd0);
    end

    // Decimation by 4 over 4096 valid samples
    do_reset();
    for (int n = 0; n < 4096; n++) send(9'(n));
    check("dec_full", {14'd0, cs4}, 16'd2);
    check("dec_d1_overflow", {15'd0, ov1}, 16'd1);
    pulse_frame();
    for (int h = 0; h < 1030; h++) begin
      hcount = 11'(h);
      tick();
      if (h == 0) check("dec_k0", {7'd0, so4}, s9(3));
      if (h == 100) check("dec_k100", {7'd0, so4}, s9(403));
      if (h == 1023) check("dec_k1023", {7'd0, so4}, s9(4095));
      if (h == 1024) begin
        check("dec_h1024_out", {7'd0, so4}, 16'd0);
        check("dec_h1024_valid", {15'd0, sv4}, 16'd0);
      end
    end

    // Rising-edge trigger at level 10
    do_reset();
    trigger_en = 1'b1;
    send(-9'sd5);
    send(9'sd5);
    send(9'sd9);
    check("trig_not_yet", {14'd0, cs1}, 16'd0);
    send(9'sd10);
    check("trig_hit", {14'd0, cs1}, 16'd1);
    send(9'sd20);
    for (int i = 0; i < DEPTH - 3; i++) feed(rnd9());
    hcount = '0;
    send(9'sd10);
    check("trig_full", {14'd0, cs1}, 16'd2);

    // Overflow while FULL, then clear together with another sample
    for (int i = 0; i < 3; i++) send(rnd9());
    check("ovf_set", {15'd0, ov1}, 16'd1);
    overflow_clr = 1'b1;
    send(9'sd10);
    overflow_clr = 1'b0;
    check("ovf_clr", {15'd0, ov1}, 16'd0);

    pulse_frame();
    hcount = 11'd0;
    tick();
    check("trig_idx0", {7'd0, so1}, s9(10));
    hcount = 11'd1;
    tick();
    check("trig_idx1", {7'd0, so1}, s9(20));

    // Flat level never produces a rising edge
    for (int i = 0; i < 30; i++) send(9'sd10);
    check("flat_no_trig", {14'd0, cs1}, 16'd0);
    send(9'sd9);
    send(9'sd10);
    check("retrig", {14'd0, cs1}, 16'd1);
    for (int i = 0; i < DEPTH - 1; i++) feed(rnd9());
    check("retrig_full", {14'd0, cs1}, 16'd2);

    // Freeze holds FULL and the displayed trace
    freeze = 1'b1;
    hcount = 11'd1;
    tick();
    for (int i = 0; i < 3; i++) begin
      pulse_frame();
      tick();
    end
    check("freeze_state", {14'd0, cs1}, 16'd2);
    check("freeze_out", {7'd0, so1}, s9(20));
    freeze = 1'b0;
    pulse_frame();
    check("unfreeze_arm", {14'd0, cs1}, 16'd0);
    hcount = 11'd0;
    tick();
    check("unfreeze_idx0", {7'd0, so1}, s9(10));

    // Reset in the middle of a fill
    trigger_en = 1'b0;
    for (int i = 0; i < 500; i++) feed(rnd9());
    hcount = 11'd0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_state", {14'd0, cs1}, 16'd0);
    check("midrst_valid", {15'd0, sv1}, 16'd0);
    first = rnd9();
    send(first);
    for (int i = 0; i < DEPTH - 1; i++) feed(rnd9());
    hcount = 11'd0;
    tick();
    check("midrst_still_hidden", {15'd0, sv1}, 16'd0);
    pulse_frame();
    tick();
    check("midrst_idx0", {7'd0, so1}, {7'd0, first});
    check("midrst_valid_after", {15'd0, sv1}, 16'd1);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
